// File: rtl/semseg_pkg.sv
// Seven-segment display controller shared types.
// Modes, glyph constants and hex glyph lookup.
package semseg_pkg;

  typedef enum logic [1:0] {
    SEG_HEX   = 2'd0,
    SEG_UDEC  = 2'd1,
    SEG_SDEC  = 2'd2,
    SEG_BLANK = 2'd3
  } seg_mode_e;

  localparam logic [6:0] MINUS = 7'b1111110;
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } glyph_t;

  function automatic logic [6:0] hex2semseg(
    input logic [3:0] n
  );
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/semseg_display_ctrl_if.sv
// Load handshake bundle between a value
// source and the display controller.
interface semseg_display_ctrl_if #(
  parameter int DIGITS = 8,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] value;
  logic [1:0]        mode;
  logic              lzs;
  logic [DIGITS-1:0] dp;
  logic              load;
  logic              ready;

  modport master (
    output value, mode, lzs, dp, load,
    input  ready
  );

  modport slave (
    input  value, mode, lzs, dp, load,
    output ready
  );
endinterface

// File: rtl/semseg_display_ctrl_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD
// converter with sticky overflow.
module bin2bcd_seq #(
  parameter int DIGITS = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     mag_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int BW = 4 * DIGITS;

  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bcd_q, bcd_d, adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  // add-3 correction then one shift per busy cycle
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i+:4] = bcd_q[4*i+:4] +
        ((bcd_q[4*i+:4] >= 4'd5) ? 4'd3 : 4'd0);
    end
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    ovf_d  = ovf_q;
    if (start_i) begin
      sh_d   = mag_i;
      bcd_d  = '0;
      cnt_d  = CW'(DATA_W);
      busy_d = 1'b1;
      ovf_d  = 1'b0;
    end else if (busy_q) begin
      bcd_d = {adj[BW-2:0], sh_q[DATA_W-1]};
      sh_d  = sh_q << 1;
      ovf_d = ovf_q | adj[BW-1];
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  // converter state registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CW'(1));
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;
endmodule

// File: rtl/semseg_display_ctrl.sv
// Multiplexed seven-segment controller:
// load FSM, atomic frame, scan refresh.
module semseg_display_ctrl
  import semseg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DATA_W = 32,
  parameter int DIV_W  = 10
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  semseg_display_ctrl_if.slave bus,
  output logic [6:0]        seg_o,
  output logic              dp_o,
  output logic [DIGITS-1:0] an_o
);
  localparam int BW = 4 * DIGITS;
  localparam int HW = (DATA_W < BW) ? DATA_W : BW;
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE, S_CONV, S_COMMIT
  } state_e;

  state_e            state_q, state_d;
  logic              lzs_q, lzs_d;
  logic              neg_q, neg_d;
  logic [DIGITS-1:0] dp_q, dp_d;
  glyph_t            frame_q [DIGITS];
  glyph_t            frame_d [DIGITS];
  glyph_t            new_fr  [DIGITS];
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIGITS-1:0] an_q, an_d;

  seg_mode_e         mode_in;
  logic              neg_in, start, frame_we;
  logic [DATA_W-1:0] mag;
  logic              bcd_busy, bcd_done, bcd_ovf;
  logic [BW-1:0]     bcd, nib;
  logic              c_lzs, c_neg, c_ovf, c_blank;
  logic [DIGITS-1:0] c_dp;
  int                msnz, mpos;
  logic              occ, ovf_all;
  logic [IW-1:0]     idx;

  assign mode_in = seg_mode_e'(bus.mode);
  assign neg_in  = (mode_in == SEG_SDEC) &
                   bus.value[DATA_W-1];
  assign mag     = neg_in ? (~bus.value + 1'b1)
                          : bus.value;
  assign bus.ready = (state_q == S_IDLE);

  bin2bcd_seq #(
    .DIGITS (DIGITS),
    .DATA_W (DATA_W)
  ) u_conv (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .start_i (start),
    .mag_i   (mag),
    .busy_o  (bcd_busy),
    .done_o  (bcd_done),
    .bcd_o   (bcd),
    .ovf_o   (bcd_ovf)
  );

  // load FSM and capture of display attributes
  always_comb begin
    state_d  = state_q;
    lzs_d    = lzs_q;
    neg_d    = neg_q;
    dp_d     = dp_q;
    start    = 1'b0;
    frame_we = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          if (mode_in == SEG_HEX ||
              mode_in == SEG_BLANK) begin
            frame_we = 1'b1;
          end else begin
            start   = 1'b1;
            lzs_d   = bus.lzs;
            neg_d   = neg_in;
            dp_d    = bus.dp;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        if (bcd_done || !bcd_busy)
          state_d = S_COMMIT;
      end
      S_COMMIT: begin
        frame_we = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // pick frame source: live hex input or finished BCD
  always_comb begin
    nib         = '0;
    nib[HW-1:0] = bus.value[HW-1:0];
    c_lzs   = bus.lzs;
    c_neg   = 1'b0;
    c_ovf   = 1'b0;
    c_blank = (mode_in == SEG_BLANK);
    c_dp    = bus.dp;
    if (state_q == S_COMMIT) begin
      nib     = bcd;
      c_lzs   = lzs_q;
      c_neg   = neg_q;
      c_ovf   = bcd_ovf;
      c_blank = 1'b0;
      c_dp    = dp_q;
    end
  end

  // suppression, sign placement and glyph build
  always_comb begin
    msnz = 0;
    for (int i = 0; i < DIGITS; i++)
      if (nib[4*i+:4] != 4'd0) msnz = i;
    mpos = c_lzs ? msnz + 1 : DIGITS - 1;
    occ  = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (i == mpos && nib[4*i+:4] != 4'd0)
        occ = 1'b1;
    ovf_all = c_ovf |
      (c_neg & (occ | (mpos >= DIGITS)));
    for (int i = 0; i < DIGITS; i++) begin
      new_fr[i].dp = ~c_dp[i];
      if (c_blank) begin
        new_fr[i].seg = BLANK;
        new_fr[i].dp  = 1'b1;
      end else if (ovf_all) begin
        new_fr[i].seg = MINUS;
        new_fr[i].dp  = 1'b1;
      end else if (c_neg && i == mpos) begin
        new_fr[i].seg = MINUS;
      end else if (c_lzs && i > msnz) begin
        new_fr[i].seg = BLANK;
      end else begin
        new_fr[i].seg = hex2semseg(nib[4*i+:4]);
      end
    end
    for (int i = 0; i < DIGITS; i++)
      frame_d[i] = frame_we ? new_fr[i]
                            : frame_q[i];
  end

  // refresh divider and anode rotation
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    an_d  = an_q;
    if (cnt_q == '0)
      an_d = {an_q[DIGITS-2:0], an_q[DIGITS-1]};
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!an_q[i]) idx = IW'(i);
  end

  // all controller state
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= S_IDLE;
      lzs_q   <= 1'b0;
      neg_q   <= 1'b0;
      dp_q    <= '0;
      cnt_q   <= '0;
      an_q    <= ~DIGITS'(1);
      for (int i = 0; i < DIGITS; i++)
        frame_q[i] <= {BLANK, 1'b1};
    end else begin
      state_q <= state_d;
      lzs_q   <= lzs_d;
      neg_q   <= neg_d;
      dp_q    <= dp_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = frame_q[idx].seg;
  assign dp_o  = frame_q[idx].dp;
endmodule

// File: tb/tb_semseg_display_ctrl.sv
// Randomised bench for semseg_display_ctrl
// against a frame-level behavioural model.
module tb_semseg_display_ctrl;
  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;
  int vectors = 0;
  int errors  = 0;

  semseg_display_ctrl_if #(
    .DIGITS(8), .DATA_W(32)
  ) bus ();

  semseg_display_ctrl #(
    .DIGITS(8), .DATA_W(32), .DIV_W(2)
  ) dut (
    .clk_i   (clk),
    .arstn_i (arst_n),
    .bus     (bus),
    .seg_o   (seg),
    .dp_o    (dp),
    .an_o    (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] hexg(input int n);
    case (n)
      0: return 7'b0000001;  1: return 7'b1001111;
      2: return 7'b0010010;  3: return 7'b0000110;
      4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;
      8: return 7'b0000000;  9: return 7'b0000100;
      10: return 7'b0001000; 11: return 7'b1100000;
      12: return 7'b0110001; 13: return 7'b1000010;
      14: return 7'b0110000; default: return 7'b0111000;
    endcase
  endfunction

  // frame as 8 bytes {seg,dp}, digit i at [8i+:8]
  function automatic logic [63:0] model(
    input logic [31:0] v, input logic [1:0] md,
    input logic lz, input logic [7:0] dpm);
    int d[8];
    longint mag, t;
    bit neg, ovf;
    int msnz, pos;
    logic [63:0] r;
    logic [6:0] s;
    if (md == 2'd3) return '1;
    neg = (md == 2'd2) && v[31];
    mag = longint'(v);
    if (neg) mag = 64'd4294967296 - mag;
    ovf = 0;
    if (md == 2'd0) begin
      for (int i = 0; i < 8; i++)
        d[i] = int'((v >> (4*i)) & 32'hF);
    end else begin
      ovf = (mag >= 100000000);
      t = mag;
      for (int i = 0; i < 8; i++) begin
        d[i] = int'(t % 10);
        t = t / 10;
      end
    end
    msnz = 0;
    for (int i = 0; i < 8; i++)
      if (d[i] != 0) msnz = i;
    pos = -1;
    if (neg) begin
      pos = lz ? msnz + 1 : 7;
      if (pos > 7) ovf = 1;
      else if (d[pos] != 0) ovf = 1;
    end
    if (ovf) return {8{8'hFD}};
    for (int i = 0; i < 8; i++) begin
      if (neg && i == pos) s = 7'b1111110;
      else if (lz && i > msnz) s = 7'b1111111;
      else s = hexg(d[i]);
      r[8*i+:8] = {s, ~dpm[i]};
    end
    return r;
  endfunction

  logic [63:0] m_frame, m_pend;
  int m_busy, m_edges;

  // reference: frame, busy window, edges since reset
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_frame <= '1;
      m_busy  <= 0;
      m_edges <= 0;
    end else begin
      m_edges <= m_edges + 1;
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) m_frame <= m_pend;
      end else if (bus.load) begin
        if (bus.mode == 2'd0 || bus.mode == 2'd3)
          m_frame <= model(bus.value, bus.mode,
                           bus.lzs, bus.dp);
        else begin
          m_pend <= model(bus.value, bus.mode,
                          bus.lzs, bus.dp);
          m_busy <= 33;
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(posedge clk) begin : cmp
    int idx;
    logic [7:0] ea;
    #2;
    idx = ((m_edges + 3) / 4) % 8;
    ea  = ~(8'b1 << idx);
    chk("an", an, ea);
    chk("ready", bus.ready, m_busy == 0);
    chk("seg", seg, m_frame[8*idx+1+:7]);
    chk("dp", dp, m_frame[8*idx]);
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
  endtask

  task automatic do_load(input logic [31:0] v,
                         input logic [1:0] md,
                         input logic lz,
                         input logic [7:0] dpm);
    int n;
    wait_ready(n);
    @(negedge clk);
    bus.value = v; bus.mode = md;
    bus.lzs = lz;  bus.dp = dpm;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic settle();
    int n;
    wait_ready(n);
    repeat (40) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return $urandom_range(0, 999);
      1: return 32'd99999999 + $urandom_range(0, 2);
      2: return -$urandom_range(1, 20000);
      3: return 32'h80000000;
      4: return -(32'd9999999 + $urandom_range(0, 2));
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    bus.value = '0; bus.mode = '0;
    bus.lzs = 1'b0; bus.dp = '0;
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 8'hFE);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_ready", bus.ready, 1'b1);
    arst_n = 1'b1;
    repeat (40) @(negedge clk);

    chk("pin_hex", model(32'h00C0FFEE, 0, 1, 8'h04),
        64'hFFFF_6303_7170_6161);
    chk("pin_neg", model(32'hFFFFFF85, 2, 1, 8'h00),
        64'hFFFF_FFFF_FD9F_250D);
    chk("pin_uovf", model(32'd100000000, 1, 0, 0),
        {8{8'hFD}});
    chk("pin_9s", model(-32'd9999999, 2, 0, 0),
        64'hFD09_0909_0909_0909);

    do_load(32'h00C0FFEE, 2'd0, 1'b1, 8'h04);
    settle();
    do_load(32'd12345, 2'd1, 1'b1, 8'h00);
    wait_ready(n);
    chk("busy_len", n, 33);
    repeat (40) @(negedge clk);
    do_load(32'd12345, 2'd1, 1'b0, 8'h00);
    settle();
    do_load(32'hFFFFFF85, 2'd2, 1'b1, 8'h00);
    settle();
    do_load(32'hFFFFFF85, 2'd2, 1'b0, 8'h00);
    settle();
    do_load(32'h80000000, 2'd2, 1'b1, 8'h00);
    settle();
    do_load(32'd100000000, 2'd1, 1'b1, 8'hFF);
    settle();
    do_load(-32'd10000000, 2'd2, 1'b0, 8'h00);
    settle();
    do_load(-32'd9999999, 2'd2, 1'b0, 8'h10);
    settle();

    do_load(32'd12345, 2'd1, 1'b1, 8'h01);
    repeat (5) @(negedge clk);
    bus.value = 32'd777; bus.mode = 2'd0;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    settle();

    do_load(32'd54321, 2'd1, 1'b0, 8'h00);
    repeat (10) @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("arst_ready", bus.ready, 1'b1);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_an", an, 8'hFE);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    do_load(32'h0000BEEF, 2'd0, 1'b0, 8'h80);
    settle();

    repeat (3000) begin
      @(negedge clk);
      bus.value = pick();
      bus.mode  = 2'($urandom_range(0, 3));
      bus.lzs   = 1'($urandom_range(0, 1));
      bus.dp    = 8'($urandom);
      bus.load  = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    bus.load = 1'b0;
    settle();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule
